sym_encoder: RTL
================

SYM_ENCODER -- requirements
Module: sym_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, input command buffer depth (entries); legal values 2 and 4 only.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present on cmd/flag.
REQ-005 cmd  input  2  command code.
REQ-006 flag  input  1  flag bit; has priority over cmd in encoding.
REQ-007 cmd_ready  output  1  buffer can accept a command this cycle.
REQ-008 sym  output  3  encoded 3-bit symbol.
REQ-009 sym_valid  output  1  sym holds a valid symbol.
REQ-010 sym_ready  input  1  downstream decoder accepts sym this cycle.
REQ-011 sent_count  output  8  number of symbols transferred, modulo 256.

Function
REQ-012 Command handshake: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1; otherwise cmd/flag are ignored, with no error.
REQ-013 cmd_ready SHALL be 1 iff buffer occupancy < FIFO_DEPTH, computed from registered state only, with no combinational path from sym_ready.
REQ-014 Buffer is FIFO-ordered; symbols leave in acceptance order, none dropped or duplicated.
REQ-015 Symbol handshake: a transfer occurs on a rising edge where sym_valid=1 and sym_ready=1.
REQ-016 While sym_valid=1 and sym_ready=0, sym SHALL hold stable.
REQ-017 Output register loads the FIFO head on an edge where (sym_valid=0 or sym_ready=1) and FIFO is non-empty; it clears sym_valid on such an edge if FIFO is empty.
REQ-018 Latency: command accepted at edge k with empty FIFO and free output stage -> sym_valid=1 after edge k+1; there is no bypass path.
REQ-019 Encoding when flag=1: sym = {1,0,t}.
REQ-020 Encoding when flag=0 and cmd=2'b10: sym = {0,t,1}.
REQ-021 Encoding in all other cases: sym = 3'b110.
REQ-022 t is a toggle bit, sampled when the output register loads; t inverts on every symbol transfer.
REQ-023 Simultaneous push and pop: occupancy unchanged; legal when full only if cmd_ready was 1, which it is not, so a full FIFO never pushes.
REQ-024 sent_count increments by 1 per transfer; 255 wraps to 0.
REQ-025 Controller state machine has states IDLE, LOADED and STALL, with these transitions:
- IDLE: sym_valid=0.
- IDLE -> LOADED when the output register loads.
- LOADED -> STALL when sym_ready=0.
- STALL -> LOADED when sym_ready=1 and the FIFO is non-empty.
- LOADED or STALL -> IDLE when a transfer occurs with the FIFO empty.

Reset
REQ-026 While reset=1 at an edge, the following SHALL take these values:
- sym_valid=0
- sym=3'b000
- sent_count=0
- t=0
- FIFO empty
- state=IDLE
- cmd_ready=1 from the following cycle
REQ-027 Reset asserted mid-transfer or with FIFO contents SHALL discard all pending commands; reset has priority over every handshake in the same cycle.

Structure
REQ-028 Shared package sym_pkg SHALL hold the state enumeration, the constants SYM_FLAG_HI=2'b10, SYM_DEFAULT=3'b110, CMD_SEL=2'b10, and the encode function.
REQ-029 FIFO SHALL be one sub-module, sym_fifo, parameterised by depth, with push/pop/full/empty ports and synchronous active-high reset.

Verification
REQ-030 Reset, then flag=1, cmd=00 with sym_ready=1:
- sym=3'b100 two edges after acceptance.
- A second identical command yields sym=3'b101.
- sent_count=2.
REQ-031 flag=0, cmd=10, then flag=0, cmd=01, then flag=0, cmd=11:
- Symbols are 3'b001, then 3'b110, then 3'b110.
- t toggles on each transfer, so a following flag=1 command gives 3'b101.
REQ-032 Hold sym_ready=0 and push 3 commands with FIFO_DEPTH=2:
- cmd_ready=0 after the third accept (FIFO 2 + output register 1).
- sym stays stable.
- The fourth cmd_valid is ignored.
- Releasing sym_ready drains exactly 3 symbols in order.
REQ-033 Continuous cmd_valid and sym_ready=1 for 300 commands:
- One symbol per cycle after the initial latency.
- sent_count wraps to 44.
REQ-034 Assert reset for 1 cycle while sym_valid=1, sym_ready=0 and FIFO full:
- Next cycle sym_valid=0, sent_count=0, cmd_ready=1.
- The pre-reset commands never appear.
REQ-035 Toggle sym_ready randomly with flag=1 commands: no sym change while stalled; the t pattern alternates 0,1,0,1 across transfers.

Source files
------------

// File: rtl/sym_pkg.sv
// Shared types, constants and the command-to-symbol encoder for sym_encoder.
package sym_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    STALL  = 2'd2
  } state_t;

  localparam logic [1:0] SYM_FLAG_HI = 2'b10;
  localparam logic [2:0] SYM_DEFAULT = 3'b110;
  localparam logic [1:0] CMD_SEL     = 2'b10;
  localparam int         CMD_W       = 3;

  // flag outranks cmd; t is the transfer-parity bit in effect at load time
  function automatic logic [2:0] encode(input logic flag, input logic [1:0] cmd,
                                        input logic t);
    logic [2:0] s;
    if (flag)                s = {SYM_FLAG_HI, t};
    else if (cmd == CMD_SEL) s = {1'b0, t, 1'b1};
    else                     s = SYM_DEFAULT;
    return s;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small synchronous FIFO holding raw {flag, cmd} entries; depth must be a power of two.
module sym_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // storage is not reset; clearing the pointers is enough to discard contents
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sym_encoder.sv
// Buffers commands, encodes them into 3-bit symbols and presents them on a
// valid/ready output register with a running transfer count.
//
//   state  | meaning
//   IDLE   | output register empty, sym_valid=0
//   LOADED | symbol presented, last cycle not stalled
//   STALL  | symbol presented and held while downstream is not ready
module sym_encoder
  import sym_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic       flag,
  output logic       cmd_ready,
  output logic [2:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [7:0] sent_count
);

  state_t           state;
  state_t           state_n;
  logic             t;
  logic             t_eff;
  logic [2:0]       sym_q;
  logic [7:0]       sent_q;
  logic             push;
  logic             load_en;
  logic             xfer;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;

  sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   ({flag, cmd}),
    .pop   (load_en),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready  = ~fifo_full;
  assign push       = cmd_valid & cmd_ready;
  assign sym_valid  = (state != IDLE);
  assign xfer       = sym_valid & sym_ready;
  assign load_en    = (~sym_valid | sym_ready) & ~fifo_empty;
  // a symbol loaded behind a transfer must see the already-toggled parity
  assign t_eff      = t ^ xfer;
  assign sym        = sym_q;
  assign sent_count = sent_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      sym_q  <= 3'b000;
      t      <= 1'b0;
      sent_q <= 8'd0;
    end else begin
      state <= state_n;
      if (load_en) sym_q <= encode(fifo_dout[2], fifo_dout[1:0], t_eff);
      if (xfer) begin
        t      <= ~t;
        sent_q <= sent_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_n = LOADED;
      end
      LOADED, STALL: begin
        if (!sym_ready)      state_n = STALL;
        else if (fifo_empty) state_n = IDLE;
        else                 state_n = LOADED;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
